// File: rtl/uart_frame_tx.sv
// ASCII telemetry framer: "K<x hex>,<p hex>[*<xor hex>]\r\n", one byte per transmitter handshake.
// First tx_start one cycle after accept; in_ready held low from accept until the cycle after frame_done.
module uart_frame_tx #(
   parameter logic [7:0] HDR_CHAR    = 8'h4B,
   parameter logic [7:0] SEP_CHAR    = 8'h2C,
   parameter bit         EN_CHECKSUM = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_x,
   input  logic [15:0] in_p,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   input  logic        tx_done,
   output logic        frame_busy,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

   localparam logic [3:0] LAST_IDX = EN_CHECKSUM ? 4'd14 : 4'd11;

   state_t      state, state_nxt;
   logic [3:0]  idx, idx_nxt;
   logic [15:0] x_q, p_q;
   logic [7:0]  csum_q, data_q, cur_byte;
   logic        accept;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
   endfunction

   always_comb begin
      cur_byte = 8'h00;
      case (idx)
         4'd0:    cur_byte = HDR_CHAR;
         4'd1:    cur_byte = hex_char(x_q[15:12]);
         4'd2:    cur_byte = hex_char(x_q[11:8]);
         4'd3:    cur_byte = hex_char(x_q[7:4]);
         4'd4:    cur_byte = hex_char(x_q[3:0]);
         4'd5:    cur_byte = SEP_CHAR;
         4'd6:    cur_byte = hex_char(p_q[15:12]);
         4'd7:    cur_byte = hex_char(p_q[11:8]);
         4'd8:    cur_byte = hex_char(p_q[7:4]);
         4'd9:    cur_byte = hex_char(p_q[3:0]);
         // Without the checksum the CR/LF tail moves up to slots 10/11.
         4'd10:   cur_byte = EN_CHECKSUM ? 8'h2A : 8'h0D;
         4'd11:   cur_byte = EN_CHECKSUM ? hex_char(csum_q[7:4]) : 8'h0A;
         4'd12:   cur_byte = hex_char(csum_q[3:0]);
         4'd13:   cur_byte = 8'h0D;
         4'd14:   cur_byte = 8'h0A;
         default: cur_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      in_ready  = 1'b0;
      tx_start  = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid) begin
               accept    = 1'b1;
               idx_nxt   = 4'd0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               tx_start  = !rst;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (tx_done) begin
               if (idx == LAST_IDX) begin
                  state_nxt = FIN;
               end else begin
                  idx_nxt   = idx + 4'd1;
                  state_nxt = SEND;
               end
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign frame_busy = !rst && (state == SEND || state == WAIT);
   assign frame_done = !rst && (state == FIN);
   assign tx_data    = tx_start ? cur_byte : data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= 4'd0;
         x_q    <= 16'h0000;
         p_q    <= 16'h0000;
         csum_q <= 8'h00;
         data_q <= 8'h00;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (accept) begin
            x_q    <= in_x;
            p_q    <= in_p;
            csum_q <= in_x[15:8] ^ in_x[7:0] ^ in_p[15:8] ^ in_p[7:0];
         end
         if (tx_start) data_q <= cur_byte;
      end
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: instance 0 has the checksum enabled, instance 1 has it disabled.
`timescale 1ns/1ps
module tb_uart_frame_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [1:0]       in_valid, in_ready, tx_start, tx_busy, tx_done;
   logic [1:0]       frame_busy, frame_done, force_busy;
   logic [1:0][15:0] in_x, in_p;
   logic [1:0][7:0]  tx_data;
   logic [1:0]       prev_start = 2'b00;

   int           checks = 0;
   int           errors = 0;
   int           starts[2];
   byte unsigned exp_q[2][$];

   typedef struct {
      int          g;
      logic [15:0] x;
      logic [15:0] p;
      string       s;
   } vec_t;
   vec_t tbl[6];

   for (genvar g = 0; g < 2; g++) begin : u
      logic       busy_r, done_r;
      logic [4:0] cnt;

      uart_frame_tx #(.HDR_CHAR(8'h4B), .SEP_CHAR(8'h2C), .EN_CHECKSUM(g == 0)) dut (
         .clk(clk), .rst(rst),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .in_x(in_x[g]), .in_p(in_p[g]),
         .tx_start(tx_start[g]), .tx_data(tx_data[g]),
         .tx_busy(tx_busy[g]), .tx_done(tx_done[g]),
         .frame_busy(frame_busy[g]), .frame_done(frame_done[g])
      );

      // Transmitter: busy the cycle after start, done pulse 20 cycles later.
      always @(posedge clk) begin
         if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cnt    <= 5'd0;
         end else begin
            done_r <= 1'b0;
            if (tx_start[g]) begin
               busy_r <= 1'b1;
               cnt    <= 5'd0;
            end else if (busy_r) begin
               if (cnt == 5'd19) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
         end
      end
      assign tx_busy[g] = busy_r | force_busy[g];
      assign tx_done[g] = done_r;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every transmitter request pops one expected byte.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst && tx_start[g]) begin
            starts[g]++;
            check("start_while_busy", 32'(tx_busy[g]), 32'd0);
            check("start_back_to_back", 32'(prev_start[g]), 32'd0);
            if (exp_q[g].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_start: inst %0d sent 0x%0h, expected no byte", g, tx_data[g]);
            end else begin
               check("tx_data", 32'(tx_data[g]), 32'(exp_q[g].pop_front()));
            end
         end
         prev_start[g] <= tx_start[g];
      end
   end

   task automatic send(input int g, input logic [15:0] x, input logic [15:0] p,
                       input string s, input bit expect_start, output int base);
      int n;
      n = 0;
      in_x[g]     = x;
      in_p[g]     = p;
      in_valid[g] = 1'b1;
      while (!in_ready[g] && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", 32'(in_ready[g]), 32'd1);
      for (int i = 0; i < s.len(); i++) exp_q[g].push_back(s[i]);
      base = starts[g];
      @(negedge clk);
      in_valid[g] = 1'b0;
      check("busy_after_accept", 32'(frame_busy[g]), 32'd1);
      check("ready_after_accept", 32'(in_ready[g]), 32'd0);
      if (expect_start) check("first_start_latency", 32'(tx_start[g]), 32'd1);
   endtask

   task automatic wait_frame(input int g, input int nbytes, input int base);
      int n, ready_hi;
      bit seen;
      n = 0;
      ready_hi = 0;
      seen = 1'b0;
      while (n < 3000 && !seen) begin
         @(negedge clk);
         n++;
         if (frame_done[g]) seen = 1'b1;
         else if (in_ready[g]) ready_hi++;
      end
      check("frame_done_seen", 32'(seen), 32'd1);
      check("ready_during_frame", 32'(ready_hi), 32'd0);
      check("start_count", 32'(starts[g] - base), 32'(nbytes));
      check("bytes_left", 32'(exp_q[g].size()), 32'd0);
      check("busy_at_done", 32'(frame_busy[g]), 32'd0);
      check("ready_at_done", 32'(in_ready[g]), 32'd0);
      @(negedge clk);
      check("done_pulse_width", 32'(frame_done[g]), 32'd0);
      check("ready_after_done", 32'(in_ready[g]), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n;
      tbl[0] = '{0, 16'h1A2F, 16'h00C3, "K1A2F,00C3*F6\015\012"};
      tbl[1] = '{1, 16'h1A2F, 16'h00C3, "K1A2F,00C3\015\012"};
      tbl[2] = '{0, 16'hFFFF, 16'h0000, "KFFFF,0000*00\015\012"};
      tbl[3] = '{0, 16'hBEEF, 16'h9C5D, "KBEEF,9C5D*90\015\012"};
      tbl[4] = '{1, 16'hABCD, 16'h1234, "KABCD,1234\015\012"};
      tbl[5] = '{1, 16'h0000, 16'hFFFF, "K0000,FFFF\015\012"};

      starts[0] = 0;
      starts[1] = 0;
      rst = 1'b1;
      in_valid = 2'b00;
      in_x = '0;
      in_p = '0;
      force_busy = 2'b00;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("rst_in_ready", 32'(in_ready[g]), 32'd0);
         check("rst_tx_start", 32'(tx_start[g]), 32'd0);
         check("rst_tx_data", 32'(tx_data[g]), 32'd0);
         check("rst_frame_busy", 32'(frame_busy[g]), 32'd0);
         check("rst_frame_done", 32'(frame_done[g]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready_0", 32'(in_ready[0]), 32'd1);
      check("idle_ready_1", 32'(in_ready[1]), 32'd1);

      for (int i = 0; i < 6; i++) begin
         send(tbl[i].g, tbl[i].x, tbl[i].p, tbl[i].s, 1'b1, base);
         wait_frame(tbl[i].g, tbl[i].s.len(), base);
      end

      // Second sample held on the input for the whole first frame; the first
      // frame must still carry the originally captured values.
      send(0, 16'hBEEF, 16'h9C5D, "KBEEF,9C5D*90\015\012", 1'b1, base);
      in_x[0] = 16'h0001;
      in_p[0] = 16'h8000;
      in_valid[0] = 1'b1;
      wait_frame(0, 15, base);
      send(0, 16'h0001, 16'h8000, "K0001,8000*81\015\012", 1'b1, base);
      wait_frame(0, 15, base);

      // Transmitter reports busy for the first 7 cycles after accept.
      force_busy[0] = 1'b1;
      send(0, 16'h1A2F, 16'h00C3, "K1A2F,00C3*F6\015\012", 1'b0, base);
      for (int i = 1; i < 7; i++) @(negedge clk);
      check("starts_while_forced_busy", 32'(starts[0] - base), 32'd0);
      @(posedge clk);
      #1 force_busy[0] = 1'b0;
      @(negedge clk);
      check("start_after_busy_drop", 32'(tx_start[0]), 32'd1);
      check("start_after_busy_data", 32'(tx_data[0]), 32'h4B);
      wait_frame(0, 15, base);

      // One-cycle reset once five bytes are under way.
      send(0, 16'hBEEF, 16'h9C5D, "KBEEF,9C5D*90\015\012", 1'b1, base);
      n = 0;
      while (starts[0] - base < 5 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("five_bytes_started", 32'(starts[0] - base), 32'd5);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      exp_q[0].delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
      check("midrst_frame_busy", 32'(frame_busy[0]), 32'd0);
      check("midrst_tx_start", 32'(tx_start[0]), 32'd0);
      check("midrst_tx_data", 32'(tx_data[0]), 32'd0);
      @(negedge clk);
      send(0, 16'h1A2F, 16'h00C3, "K1A2F,00C3*F6\015\012", 1'b1, base);
      wait_frame(0, 15, base);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Telemetry framer directly upstream of the UART byte transmitter.
- Accepts one filter output sample, a 16-bit state estimate and a 16-bit covariance, per valid/ready handshake.
- Formats the sample as an ASCII frame and feeds it to the transmitter one byte at a time over its start/busy/done interface.
- Hosts read filter results on a serial terminal without any decoding software.

Parameters:
- HDR_CHAR, 8'h4B ('K'): first byte of every frame.
- SEP_CHAR, 8'h2C (','): byte between the two hex fields.
- EN_CHECKSUM, 1: 1 appends '*' plus a 2-char hex XOR checksum; 0 omits both.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  sample present
- in_ready  out  1  framer can accept a sample
- in_x  in  16  state estimate, raw bits
- in_p  in  16  covariance, raw bits
- tx_start  out  1  one-cycle byte request to the transmitter
- tx_data  out  8  byte to send; valid while tx_start=1
- tx_busy  in  1  transmitter busy
- tx_done  in  1  one-cycle pulse, byte fully sent (stop bit complete)
- frame_busy  out  1  high from sample accept until the last byte's tx_done
- frame_done  out  1  one-cycle pulse after the last byte completes

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Interface signal names follow the codebase conventions.
- Frame with EN_CHECKSUM=1 is 15 bytes: HDR, X3 X2 X1 X0, SEP, P3 P2 P1 P0, '*', C1 C0, 0x0D, 0x0A.
- Frame with EN_CHECKSUM=0 is 12 bytes: the '*' and C1 C0 bytes are removed.
- Hex encoding: nibble 0-9 maps to 0x30-0x39; nibble A-F maps to uppercase 0x41-0x46. Most significant nibble is sent first.
- Checksum: C = in_x[15:8] ^ in_x[7:0] ^ in_p[15:8] ^ in_p[7:0]. It is computed on the captured sample.
- Reset: state IDLE, byte index 0, in_ready=0 during reset, tx_start=0, tx_data=0, frame_busy=0, frame_done=0. Capture registers are cleared to 0.
- FSM states: IDLE, SEND, WAIT, FIN.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture in_x, in_p and the checksum; set index 0, set frame_busy=1, go to SEND.
- SEND:
  - in_ready=0.
  - If tx_busy=0: assert tx_start=1 for exactly this cycle with tx_data = byte[index], then go to WAIT.
  - If tx_busy=1: hold in SEND with tx_start=0.
- WAIT:
  - tx_start=0; tx_data holds its value.
  - On tx_done: if index is the last index, go to FIN; otherwise increment index and go to SEND.
  - Any tx_done seen while not in WAIT is ignored.
- FIN: frame_done=1 for this cycle, frame_busy cleared, next state IDLE.
- Latency:
  - Accept in cycle T; first tx_start in cycle T+1 if tx_busy=0.
  - Byte k+1's tx_start comes 1 cycle after byte k's tx_done.
  - frame_done comes 1 cycle after the last tx_done.
  - in_ready rises in the cycle after frame_done.
- Each byte produces exactly one tx_start pulse. tx_start is never asserted in two consecutive cycles and never while tx_busy=1.
- Backpressure: in_ready=0 whenever state≠IDLE. Samples presented while busy are not consumed, so the upstream must hold in_valid.
- Index is 4 bits. The last index is 14 (checksum enabled) or 11 (checksum disabled). The index never wraps mid-frame.
- Changes on in_x/in_p after acceptance do not affect the frame in flight.
- Reset mid-frame: the block returns to IDLE in the next cycle and the partial frame is abandoned. The transmitter is reset by the same system reset.

Test Plan:
- EN_CHECKSUM=1; accept x=0x1A2F, p=0x00C3; transmitter model sets busy 1 cycle after start and pulses done 20 cycles later. Required: tx_data sequence 4B 31 41 32 46 2C 30 30 43 33 2A 46 36 0D 0A, i.e. "K1A2F,00C3*F6\r\n". Exactly 15 tx_start pulses, then one frame_done.
- EN_CHECKSUM=0 with the same sample. Required: 12 bytes "K1A2F,00C3\r\n", last byte 0x0A, frame_done after the 12th tx_done.
- Accept x=0xFFFF, p=0x0000. Required: "KFFFF,0000*00\r\n"; verifies the 0xFF^0xFF^0^0 = 0x00 case and the uppercase 'F' code 0x46.
- Hold in_valid=1 with a second sample (0x0001, 0x8000) throughout frame 1. Required:
  - in_ready stays 0 until the cycle after frame_done.
  - The second frame is "K0001,8000*81\r\n".
  - No sample is lost or duplicated.
- Hold tx_busy=1 for 7 cycles after accept. Required: tx_start stays 0, then pulses once in the first cycle with tx_busy=0.
- Assert rst for 1 cycle after byte 5 of a frame. Required: the next cycle shows IDLE with in_ready=1, frame_busy=0, tx_start=0. A new frame then starts with byte 0x4B.
